// File: rtl/register_file.sv
// RISC-V integer register file: NREGS x XLEN flop array, x0 hardwired to zero,
// two registered read ports with write-through bypass and one write port.
module register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rd_en,
  input  logic            we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs_valid
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic            rs_valid_q, rs_valid_d;
  logic            wr_ok;

  // x0 and out-of-range addresses are never backed by storage
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_W);
  endfunction

  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   a,
    input logic            w_en,
    input logic [AW-1:0]   w_addr,
    input logic [XLEN-1:0] w_data,
    input logic [XLEN-1:0] arr_val
  );
    if (!addr_ok(a))
      return '0;
    else if (w_en && (w_addr == a))
      return w_data;
    else
      return arr_val;
  endfunction

  assign wr_ok = we && addr_ok(rd_addr);

  always_comb begin
    regs_d = regs_q;
    if (wr_ok)
      regs_d[rd_addr] = wdata;
    regs_d[0] = '0;
  end

  always_comb begin
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs_valid_d = rd_en;
    if (rd_en) begin
      rs1_data_d = read_port(rs1_addr, we, rd_addr, wdata,
                             addr_ok(rs1_addr) ? regs_q[rs1_addr] : '0);
      rs2_data_d = read_port(rs2_addr, we, rd_addr, wdata,
                             addr_ok(rs2_addr) ? regs_q[rs2_addr] : '0);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs_valid_q <= rs_valid_d;
    end
  end

  assign rs1_data = rs1_data_q;
  assign rs2_data = rs2_data_q;
  assign rs_valid = rs_valid_q;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expectations queued at stimulus time,
// popped and compared after the capturing edge.
module tb_register_file;

  logic        clock;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rd_en, we;
  logic [31:0] wdata;
  logic [31:0] rs1_data, rs2_data;
  logic        rs_valid;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ev;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  register_file #(.XLEN(32), .NREGS(32), .AW(5)) dut (
    .clock    (clock),
    .reset    (reset),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_en    (rd_en),
    .we       (we),
    .rd_addr  (rd_addr),
    .wdata    (wdata),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rs_valid (rs_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of stimulus at the falling edge, optionally queue the
  // expected outputs, then return 1 time unit after the capturing rising edge.
  task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic re, input logic [4:0] a1, input logic [4:0] a2,
                      input logic chk, input logic [31:0] e1, input logic [31:0] e2,
                      input logic ev);
    exp_t x;
    @(negedge clock);
    we = w; rd_addr = wa; wdata = wd;
    rd_en = re; rs1_addr = a1; rs2_addr = a2;
    if (chk) begin
      x.e1 = e1; x.e2 = e2; x.ev = ev;
      sb.push_back(x);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    we = 0; rd_en = 0; rd_addr = 0; wdata = 0; rs1_addr = 0; rs2_addr = 0;
    #2;
    n_cmp++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || rs_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_initial: got %h/%h/%b need 0/0/0", rs1_data, rs2_data, rs_valid);
    end
    #10 reset = 1'b1;
    step(1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 5'd5, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    e = sb.pop_front(); n_cmp++;
    if (rs1_data !== e.e1 || rs2_data !== e.e2 || rs_valid !== e.ev) begin
      n_err++;
      $display("FAIL reset_prefill: got %h/%h/%b need %h/%h/%b", rs1_data, rs2_data, rs_valid, e.e1, e.e2, e.ev);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || rs_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: got %h/%h/%b need 0/0/0", rs1_data, rs2_data, rs_valid);
    end
    // attempt a write and read while reset is held across an edge
    we = 1; rd_addr = 5'd5; wdata = 32'h11111111; rd_en = 1; rs1_addr = 5'd5; rs2_addr = 5'd5;
    @(posedge clock); #1;
    n_cmp++;
    if (rs1_data !== 32'h0 || rs_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_held: got %h/%b need 0/0", rs1_data, rs_valid);
    end
    @(negedge clock);
    we = 0; rd_en = 0;
    #2 reset = 1'b1;
    step(0, 5'd0, 32'h0, 1, 5'd5, 5'd5, 1, 32'h0, 32'h0, 1);
    e = sb.pop_front(); n_cmp++;
    if (rs1_data !== e.e1 || rs2_data !== e.e2 || rs_valid !== e.ev) begin
      n_err++;
      $display("FAIL reset_cleared_x5: got %h/%h/%b need %h/%h/%b", rs1_data, rs2_data, rs_valid, e.e1, e.e2, e.ev);
    end
  endtask

  task automatic test_basic;
    step(1, 5'd1, 32'h12345678, 0, 5'd0, 5'd0, 0, 0, 0, 0);
    n_cmp++;
    if (rs_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_idle_valid: got %b need 0", rs_valid);
    end
    step(0, 5'd0, 32'h0, 1, 5'd1, 5'd0, 1, 32'h12345678, 32'h0, 1);
    e = sb.pop_front(); n_cmp++;
    if (rs1_data !== e.e1 || rs2_data !== e.e2 || rs_valid !== e.ev) begin
      n_err++;
      $display("FAIL basic_x1: got %h/%h/%b need %h/%h/%b", rs1_data, rs2_data, rs_valid, e.e1, e.e2, e.ev);
    end
  endtask

  task automatic test_x0;
    step(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0, 0, 0, 0, 0);
    step(0, 5'd0, 32'h0, 1, 5'd0, 5'd0, 1, 32'h0, 32'h0, 1);
    e = sb.pop_front(); n_cmp++;
    if (rs1_data !== e.e1 || rs2_data !== e.e2 || rs_valid !== e.ev) begin
      n_err++;
      $display("FAIL x0_read: got %h/%h/%b need %h/%h/%b", rs1_data, rs2_data, rs_valid, e.e1, e.e2, e.ev);
    end
    step(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0, 1, 32'h0, 32'h0, 1);
    e = sb.pop_front(); n_cmp++;
    if (rs1_data !== e.e1 || rs2_data !== e.e2 || rs_valid !== e.ev) begin
      n_err++;
      $display("FAIL x0_bypass: got %h/%h/%b need %h/%h/%b", rs1_data, rs2_data, rs_valid, e.e1, e.e2, e.ev);
    end
  endtask

  task automatic test_bypass;
    step(1, 5'd7, 32'hA5A5A5A5, 1, 5'd7, 5'd7, 1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1);
    e = sb.pop_front(); n_cmp++;
    if (rs1_data !== e.e1 || rs2_data !== e.e2 || rs_valid !== e.ev) begin
      n_err++;
      $display("FAIL bypass_same_edge: got %h/%h/%b need %h/%h/%b", rs1_data, rs2_data, rs_valid, e.e1, e.e2, e.ev);
    end
    step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
    step(0, 5'd0, 32'h0, 1, 5'd1, 5'd7, 1, 32'h12345678, 32'hA5A5A5A5, 1);
    e = sb.pop_front(); n_cmp++;
    if (rs1_data !== e.e1 || rs2_data !== e.e2 || rs_valid !== e.ev) begin
      n_err++;
      $display("FAIL bypass_later_read: got %h/%h/%b need %h/%h/%b", rs1_data, rs2_data, rs_valid, e.e1, e.e2, e.ev);
    end
  endtask

  task automatic test_hold;
    step(1, 5'd3, 32'h00000033, 0, 5'd0, 5'd0, 0, 0, 0, 0);
    step(0, 5'd0, 32'h0, 1, 5'd3, 5'd3, 1, 32'h33, 32'h33, 1);
    e = sb.pop_front(); n_cmp++;
    if (rs1_data !== e.e1 || rs2_data !== e.e2 || rs_valid !== e.ev) begin
      n_err++;
      $display("FAIL hold_first_read: got %h/%h/%b need %h/%h/%b", rs1_data, rs2_data, rs_valid, e.e1, e.e2, e.ev);
    end
    step(1, 5'd3, 32'h00000044, 0, 5'd3, 5'd3, 1, 32'h33, 32'h33, 0);
    e = sb.pop_front(); n_cmp++;
    if (rs1_data !== e.e1 || rs2_data !== e.e2 || rs_valid !== e.ev) begin
      n_err++;
      $display("FAIL hold_disabled: got %h/%h/%b need %h/%h/%b", rs1_data, rs2_data, rs_valid, e.e1, e.e2, e.ev);
    end
    step(0, 5'd0, 32'h0, 1, 5'd3, 5'd3, 1, 32'h44, 32'h44, 1);
    e = sb.pop_front(); n_cmp++;
    if (rs1_data !== e.e1 || rs2_data !== e.e2 || rs_valid !== e.ev) begin
      n_err++;
      $display("FAIL hold_reenabled: got %h/%h/%b need %h/%h/%b", rs1_data, rs2_data, rs_valid, e.e1, e.e2, e.ev);
    end
  endtask

  task automatic test_back_to_back;
    step(1, 5'd9, 32'hCAFEF00D, 0, 5'd0, 5'd0, 0, 0, 0, 0);
    // x9 from the array while x10 is written and read through the bypass
    step(1, 5'd10, 32'h0BADC0DE, 1, 5'd9, 5'd10, 1, 32'hCAFEF00D, 32'h0BADC0DE, 1);
    e = sb.pop_front(); n_cmp++;
    if (rs1_data !== e.e1 || rs2_data !== e.e2 || rs_valid !== e.ev) begin
      n_err++;
      $display("FAIL b2b_mixed: got %h/%h/%b need %h/%h/%b", rs1_data, rs2_data, rs_valid, e.e1, e.e2, e.ev);
    end
    step(1, 5'd9, 32'h00000099, 1, 5'd10, 5'd9, 1, 32'h0BADC0DE, 32'h00000099, 1);
    e = sb.pop_front(); n_cmp++;
    if (rs1_data !== e.e1 || rs2_data !== e.e2 || rs_valid !== e.ev) begin
      n_err++;
      $display("FAIL b2b_overwrite: got %h/%h/%b need %h/%h/%b", rs1_data, rs2_data, rs_valid, e.e1, e.e2, e.ev);
    end
  endtask

  task automatic test_sweep;
    for (int i = 1; i < 32; i++)
      step(1, 5'(i), 32'(i) * 32'h01010101, 0, 5'd0, 5'd0, 0, 0, 0, 0);
    for (int i = 1; i < 32; i++) begin
      step(0, 5'd0, 32'h0, 1, 5'(i), 5'(32 - i), 1,
           32'(i) * 32'h01010101, 32'(32 - i) * 32'h01010101, 1);
      e = sb.pop_front(); n_cmp++;
      if (rs1_data !== e.e1 || rs2_data !== e.e2 || rs_valid !== e.ev) begin
        n_err++;
        $display("FAIL sweep_pair_%0d: got %h/%h/%b need %h/%h/%b", i, rs1_data, rs2_data, rs_valid, e.e1, e.e2, e.ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_x0();
    test_bypass();
    test_hold();
    test_back_to_back();
    test_sweep();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover need 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
